// File: rtl/capture_wr_ctrl_if.sv
// capture_wr_ctrl_if: probe/stop inputs and trace-memory write and status outputs
interface capture_wr_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_ce;
  logic                  stopped;
  logic                  i_rearm;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  primed;
  logic [ADDR_WIDTH-1:0] o_oldest;
  logic                  o_done;
  modport master (
    output i_data, i_ce, stopped, i_rearm,
    input  waddr, wen, wdata, primed, o_oldest, o_done
  );
  modport slave (
    input  i_data, i_ce, stopped, i_rearm,
    output waddr, wen, wdata, primed, o_oldest, o_done
  );
endinterface

// File: rtl/capture_wr_ctrl.sv
// capture_wr_ctrl: circular trace-memory writer with fill/prime, stop freeze and rearm
module capture_wr_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  capture_wr_ctrl_if.slave bus
);
  typedef enum logic [1:0] {FILL = 2'b00, PRIMED = 2'b01, STOPPED = 2'b10} state_t;
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, waddr, oldest;
  logic [ADDR_WIDTH:0]   fill_cnt, fill_inc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wen, primed, done, accept, stop_hit, fill_hit;
  // sample qualification and FILL -> PRIMED -> STOPPED sequencing; rearm overrides all
  always_comb begin
    accept    = bus.i_ce && !bus.i_rearm && state != STOPPED && !(state == PRIMED && bus.stopped);
    stop_hit  = !bus.i_rearm && state == PRIMED && bus.stopped;
    fill_inc  = fill_cnt == DEPTH ? fill_cnt : fill_cnt + 1'b1;
    fill_hit  = accept && state == FILL && fill_inc == DEPTH;
    state_nxt = bus.i_rearm     ? FILL :
                stop_hit        ? STOPPED :
                fill_hit        ? PRIMED :
                state == STOPPED ? STOPPED :
                state == PRIMED  ? PRIMED : FILL;
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FILL;
    else state <= state_nxt;
  // write port, fill tracking and stop snapshot; all outputs registered
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ptr      <= '0;
      fill_cnt <= '0;
      waddr    <= '0;
      wen      <= 1'b0;
      wdata    <= '0;
      primed   <= 1'b0;
      oldest   <= '0;
      done     <= 1'b0;
    end else if (bus.i_rearm) begin
      ptr      <= '0;
      fill_cnt <= '0;
      primed   <= 1'b0;
      done     <= 1'b0;
      wen      <= 1'b0;
    end else begin
      wen <= accept;
      if (accept) begin
        waddr    <= ptr;
        wdata    <= bus.i_data;
        ptr      <= ptr + 1'b1;
        fill_cnt <= fill_inc;
      end
      if (fill_hit) primed <= 1'b1;
      if (stop_hit) begin
        done   <= 1'b1;
        oldest <= ptr;
      end
    end
  assign bus.waddr    = waddr;
  assign bus.wen      = wen;
  assign bus.wdata    = wdata;
  assign bus.primed   = primed;
  assign bus.o_oldest = oldest;
  assign bus.o_done   = done;
endmodule
